ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Parametrised iterative RV32M multiply/divide unit for the EX stage of the 5-stage pipeline.
//  Accepts one M-extension op at a time and stalls the front end (PC, IF/ID, ID/EX) until its result is ready.
//  Hands the result and rd to EX/MEM alongside the ALU path.
//  Successor to the single-cycle ALU-only EX stage: adds multi-cycle latency, a stall handshake and flush.
// PARAMETERS
//  XLEN   32  operand/result width; must be even, >=8
//  UNROLL 1   quotient/product bits retired per CALC cycle; legal 1,2,4; must divide XLEN
// PORTS
//  i_clk      in   1     clock, rising edge
//  i_rst      in   1     reset; asynchronous, active-low
//  i_clk_en   in   1     global clock enable; low freezes all state
//  i_valid_e  in   1     M-op present in EX (opcode 0110011, funct7 0000001)
//  i_op_e     in   3     funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  i_op_a_e   in   XLEN  rs1 value after forwarding
//  i_op_b_e   in   XLEN  rs2 value after forwarding
//  i_rd_e     in   5     destination register
//  i_flush_h  in   1     kill the in-flight op (branch/jump redirect)
//  o_stall_h  out  1     stall PC/IF_ID/ID_EX this cycle
//  o_busy     out  1     state != IDLE
//  o_done     out  1     one-cycle result strobe
//  o_result   out  XLEN  result; valid while o_done is high
//  o_rd       out  5     rd of completed op
// BEHAVIOUR
//  - Reset: state IDLE; o_done=0, o_busy=0, o_result=0, o_rd=0; all internal registers cleared.
//  - FSM IDLE -> CALC -> DONE -> IDLE.
//    IDLE: on i_valid_e, latch op, |a|, |b|, sign flags and rd; go to CALC.
//    CALC: run for XLEN/UNROLL cycles, then go to DONE.
//    DONE: o_done=1 for exactly one cycle; return to IDLE.
//  - o_stall_h = i_valid_e & (state != DONE), combinational. Low in DONE, so the op advances to MEM in that cycle.
//  - Latency: accept edge to o_done = XLEN/UNROLL + 1 cycles (33 at defaults).
//  - Multiply: shift-add on unsigned magnitudes into a 2*XLEN accumulator.
//    MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
//    Negate the full 2*XLEN product when operand signs differ (per op signedness).
//  - Divide: restoring divider on magnitudes.
//    Quotient sign = sa^sb; remainder takes the sign of the dividend.
//  - Special cases skip CALC (IDLE -> DONE, latency 1):
//    divide by zero: DIV/DIVU q = all-ones, REM/REMU r = dividend.
//    signed overflow (-2^(XLEN-1) / -1): q = dividend, r = 0.
//  - i_flush_h in any state: next state IDLE, no o_done, o_result holds its old value. Flush beats completion in DONE.
//  - i_clk_en=0: state, counters and outputs hold. o_stall_h is still computed from the current state.
//  - Reset asserted mid-op: immediate return to reset values; the op is lost.
//  - o_result/o_rd hold the last completed value until the next completion.
//  - i_valid_e while busy is ignored, since the pipeline is stalled and holds the same op.
// CONFIGURATION
//  - MULDIV_FAST_MUL_EN defined:
//    MUL* ops compute the product with a single 2*XLEN '*' (signed-extended operands) and go IDLE -> DONE (latency 1).
//    Divide is unchanged.
//  - Undefined: all multiplies are iterative per UNROLL; no hardware multiplier is inferred.
// STRUCTURE
//  - Shared package muldiv_pkg:
//    funct3 encodings as localparams (OP_MUL..OP_REMU)
//    state encoding ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2
//    M-ext funct7 constant 7'b0000001
//  - One sub-module, muldiv_sign_fix (combinational):
//    operand magnitude/sign extraction on accept
//    result negation and hi/lo select at DONE
//  - FSM, counter and datapath registers stay in ex_muldiv_unit.
// TESTING
//  1. MUL 7*-3 (XLEN=32, UNROLL=1) -> o_stall_h high 33 cycles; o_done at cycle 33; o_result=32'hFFFF_FFEB.
//  2. MULHU 32'hFFFF_FFFF*32'hFFFF_FFFF -> 32'hFFFF_FFFE. MULH same operands -> 32'h0000_0000.
//     MULHSU -1*2 -> 32'hFFFF_FFFF.
//  3. DIV -7/2 -> q=32'hFFFF_FFFD; REM -7/2 -> 32'hFFFF_FFFF; DIVU 100/7 -> 14; REMU -> 2.
//  4. DIV 5/0 -> 32'hFFFF_FFFF and REM 5/0 -> 5, o_done 1 cycle after accept.
//     DIV 32'h8000_0000/-1 -> 32'h8000_0000; REM -> 0.
//  5. i_flush_h at CALC cycle 10 -> IDLE next cycle, no o_done, o_result unchanged.
//     i_rst low at cycle 20 of a new op -> all outputs 0.
//  6. i_clk_en low for 5 cycles mid-CALC -> o_done delayed by exactly 5 cycles, result correct.
//     Repeat tests 1-4 with UNROLL=4 (latency 9) and with MULDIV_FAST_MUL_EN (MUL latency 1).

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 op codes, FSM states,
// the M-extension funct7 value and small decode helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Context captured when an op is accepted; sign flags are already cleared for
  // results that were produced directly at accept time.
  typedef struct packed {
    logic [2:0] op;
    logic       neg_a;
    logic       neg_b;
    logic [4:0] rd;
  } op_ctx_t;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: magnitude/sign extraction of incoming operands and
// final negation plus hi/lo or quotient/remainder selection of the finished result.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  output logic              neg_a,
  output logic              neg_b,
  input  logic [2:0]        res_op,
  input  logic [2*XLEN-1:0] acc,
  input  logic              res_neg_a,
  input  logic              res_neg_b,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  always_comb begin
    neg_a = op_a_signed(op) & op_a[XLEN-1];
    neg_b = op_b_signed(op) & op_b[XLEN-1];
    mag_a = neg_a ? -op_a : op_a;
    mag_b = neg_b ? -op_b : op_b;
  end

  // acc holds {hi, lo} product for multiplies and {remainder, quotient} for divides.
  always_comb begin
    prod = (res_neg_a ^ res_neg_b) ? -acc : acc;
    quo  = (res_neg_a ^ res_neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = res_neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (res_op)
      OP_MUL:                       result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = quo;
      default:                      result = rem;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage with front-end stall and flush.
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle multiplier (divide stays iterative).
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clk_en,
  input  logic            i_valid_e,
  input  logic [2:0]      i_op_e,
  input  logic [XLEN-1:0] i_op_a_e,
  input  logic [XLEN-1:0] i_op_b_e,
  input  logic [4:0]      i_rd_e,
  input  logic            i_flush_h,
  output logic            o_stall_h,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [2*XLEN-1:0] acc_reg, acc_load;
  logic [XLEN-1:0]   div_reg;
  op_ctx_t           ctx_reg, ctx_load;
  logic [XLEN-1:0]   result_reg;
  logic [4:0]        rd_reg;

  logic [XLEN-1:0] mag_a, mag_b, fixed_result;
  logic            neg_a, neg_b;
  logic            div_zero, overflow, skip_calc;

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op        (i_op_e),
    .op_a      (i_op_a_e),
    .op_b      (i_op_b_e),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .neg_a     (neg_a),
    .neg_b     (neg_b),
    .res_op    (ctx_reg.op),
    .acc       (acc_reg),
    .res_neg_a (ctx_reg.neg_a),
    .res_neg_b (ctx_reg.neg_b),
    .result    (fixed_result)
  );

  // UNROLL chained steps; each is either a shift-add multiply or a restoring divide step.
  logic [2*XLEN-1:0] stage [UNROLL+1];
  assign stage[0] = acc_reg;

  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            ge;

    assign add_sum = {1'b0, stage[gi][2*XLEN-1:XLEN]} +
                     (stage[gi][0] ? {1'b0, div_reg} : '0);
    assign shifted = {stage[gi][2*XLEN-1:XLEN], stage[gi][XLEN-1]};
    assign ge      = shifted >= {1'b0, div_reg};
    assign diff    = shifted[XLEN-1:0] - div_reg;
    assign stage[gi+1] = ctx_reg.op[2]
                       ? {(ge ? diff : shifted[XLEN-1:0]), stage[gi][XLEN-2:0], ge}
                       : {add_sum, stage[gi][XLEN-1:1]};
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
  assign ext_a     = {{XLEN{op_a_signed(i_op_e) & i_op_a_e[XLEN-1]}}, i_op_a_e};
  assign ext_b     = {{XLEN{op_b_signed(i_op_e) & i_op_b_e[XLEN-1]}}, i_op_b_e};
  assign fast_prod = ext_a * ext_b;
`endif

  assign div_zero = i_op_e[2] && (i_op_b_e == '0);
  assign overflow = ((i_op_e == OP_DIV) || (i_op_e == OP_REM)) &&
                    (i_op_a_e == {1'b1, {(XLEN-1){1'b0}}}) && (&i_op_b_e);

  // Results known at accept are parked in acc with sign flags cleared, so the
  // common sign-fix path passes them through unchanged.
  always_comb begin
    acc_load       = {{XLEN{1'b0}}, mag_a};
    ctx_load       = '0;
    ctx_load.op    = i_op_e;
    ctx_load.neg_a = neg_a;
    ctx_load.neg_b = neg_b;
    ctx_load.rd    = i_rd_e;
    skip_calc      = 1'b0;
    if (div_zero) begin
      acc_load       = {i_op_a_e, {XLEN{1'b1}}};
      ctx_load.neg_a = 1'b0;
      ctx_load.neg_b = 1'b0;
      skip_calc      = 1'b1;
    end else if (overflow) begin
      acc_load       = {{XLEN{1'b0}}, i_op_a_e};
      ctx_load.neg_a = 1'b0;
      ctx_load.neg_b = 1'b0;
      skip_calc      = 1'b1;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!i_op_e[2]) begin
      acc_load       = fast_prod;
      ctx_load.neg_a = 1'b0;
      ctx_load.neg_b = 1'b0;
      skip_calc      = 1'b1;
    end
`endif
  end

  always_comb begin
    state_next = state_reg;
    if (i_flush_h) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (i_valid_e) state_next = skip_calc ? ST_DONE : ST_CALC;
        ST_CALC: if (cnt_reg == CNT_LAST) state_next = ST_DONE;
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      div_reg    <= '0;
      ctx_reg    <= '0;
      result_reg <= '0;
      rd_reg     <= '0;
    end else if (i_clk_en) begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (i_valid_e && !i_flush_h) begin
            acc_reg <= acc_load;
            div_reg <= mag_b;
            ctx_reg <= ctx_load;
            cnt_reg <= '0;
          end
        end
        ST_CALC: begin
          acc_reg <= stage[UNROLL];
          cnt_reg <= cnt_reg + 1'b1;
        end
        ST_DONE: begin
          if (!i_flush_h) begin
            result_reg <= fixed_result;
            rd_reg     <= ctx_reg.rd;
          end
        end
        default: ;
      endcase
    end
  end

  // The finished value is presented during DONE and retained afterwards; a flush
  // in DONE suppresses both the strobe and the update.
  assign o_busy    = (state_reg != ST_IDLE);
  assign o_stall_h = i_valid_e & (state_reg != ST_DONE);
  assign o_done    = (state_reg == ST_DONE) & ~i_flush_h;
  assign o_result  = o_done ? fixed_result : result_reg;
  assign o_rd      = o_done ? ctx_reg.rd : rd_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (honours MULDIV_FAST_MUL_EN for multiply latency).
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN     = 32;
  localparam int UNROLL   = 1;
  localparam int STEPS    = XLEN / UNROLL;
  localparam int DIV_LAT  = STEPS + 1;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
`else
  localparam int MUL_LAT  = STEPS + 1;
`endif
  localparam int FLUSH_AT = (STEPS > 10) ? 10 : STEPS - 1;
  localparam int RESET_AT = (STEPS > 20) ? 20 : STEPS - 1;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic            i_clk_en = 1'b1;
  logic            i_valid_e = 1'b0;
  logic [2:0]      i_op_e = '0;
  logic [XLEN-1:0] i_op_a_e = '0;
  logic [XLEN-1:0] i_op_b_e = '0;
  logic [4:0]      i_rd_e = '0;
  logic            i_flush_h = 1'b0;
  logic            o_stall_h, o_busy, o_done;
  logic [XLEN-1:0] o_result;
  logic [4:0]      o_rd;

  int errors = 0;
  int checks = 0;

  ex_muldiv_unit #(.XLEN(XLEN), .UNROLL(UNROLL)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clk_en  (i_clk_en),
    .i_valid_e (i_valid_e),
    .i_op_e    (i_op_e),
    .i_op_a_e  (i_op_a_e),
    .i_op_b_e  (i_op_b_e),
    .i_rd_e    (i_rd_e),
    .i_flush_h (i_flush_h),
    .o_stall_h (o_stall_h),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_result  (o_result),
    .o_rd      (o_rd)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Presents one op, holds it until o_done (bounded), optionally freezing i_clk_en,
  // then lets the unit return to IDLE.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int freeze_at, input int freeze_len,
                        output logic [31:0] res, output logic [4:0] rdo, output int lat,
                        output int stalls, output logic stall_done);
    lat = 0; stalls = 0; res = '0; rdo = '0; stall_done = 1'b1;
    i_valid_e = 1'b1; i_op_e = op; i_op_a_e = a; i_op_b_e = b; i_rd_e = rd;
    #1;
    if (o_stall_h) stalls++;
    while (lat < 200) begin
      @(posedge i_clk); #1;
      lat++;
      if (o_done) begin
        res = o_result; rdo = o_rd; stall_done = o_stall_h;
        break;
      end
      if (o_stall_h) stalls++;
      if (lat == freeze_at) i_clk_en = 1'b0;
      if (lat == freeze_at + freeze_len) i_clk_en = 1'b1;
    end
    i_valid_e = 1'b0; i_clk_en = 1'b1;
    $display("op=%0d a=%h b=%h rd=%0d -> result=%h rd=%0d latency=%0d", op, a, b, rd, res, rdo, lat);
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", o_done); end
    checks++; if (o_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h required 0", o_result); end
    checks++; if (o_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d required 0", o_rd); end
    checks++; if (o_stall_h !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", o_stall_h); end
    i_rst = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_mul();
    logic [31:0] res; logic [4:0] rdo; int lat, stalls; logic sd;
    run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, 0, res, rdo, lat, stalls, sd);
    checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mul_latency: got %0d required %0d", lat, MUL_LAT); end
    checks++; if (stalls !== MUL_LAT) begin errors++; $display("FAIL mul_stall_cycles: got %0d required %0d", stalls, MUL_LAT); end
    checks++; if (sd !== 1'b0) begin errors++; $display("FAIL mul_stall_in_done: got %b required 0", sd); end
    checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h required ffffffeb", res); end
    checks++; if (rdo !== 5'd5) begin errors++; $display("FAIL mul_rd: got %0d required 5", rdo); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL mul_done_one_cycle: got %b required 0", o_done); end
    checks++; if (o_result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result_hold: got %h required ffffffeb", o_result); end
  endtask

  task automatic test_mulh();
    vec_t v[3];
    logic [31:0] res; logic [4:0] rdo; int lat, stalls; logic sd;
    v[0] = '{op: OP_MULHU,  a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFE, lat: MUL_LAT};
    v[1] = '{op: OP_MULH,   a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: 32'h0000_0000, lat: MUL_LAT};
    v[2] = '{op: OP_MULHSU, a: 32'hFFFF_FFFF, b: 32'h0000_0002, exp: 32'hFFFF_FFFF, lat: MUL_LAT};
    for (int i = 0; i < 3; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, 5'(10 + i), 0, 0, res, rdo, lat, stalls, sd);
      checks++; if (res !== v[i].exp) begin errors++; $display("FAIL mulh_result[%0d]: got %h required %h", i, res, v[i].exp); end
      checks++; if (lat !== v[i].lat) begin errors++; $display("FAIL mulh_latency[%0d]: got %0d required %0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_div();
    vec_t v[4];
    logic [31:0] res; logic [4:0] rdo; int lat, stalls; logic sd;
    v[0] = '{op: OP_DIV,  a: 32'hFFFF_FFF9, b: 32'd2, exp: 32'hFFFF_FFFD, lat: DIV_LAT};
    v[1] = '{op: OP_REM,  a: 32'hFFFF_FFF9, b: 32'd2, exp: 32'hFFFF_FFFF, lat: DIV_LAT};
    v[2] = '{op: OP_DIVU, a: 32'd100,       b: 32'd7, exp: 32'd14,        lat: DIV_LAT};
    v[3] = '{op: OP_REMU, a: 32'd100,       b: 32'd7, exp: 32'd2,         lat: DIV_LAT};
    for (int i = 0; i < 4; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, 5'(20 + i), 0, 0, res, rdo, lat, stalls, sd);
      checks++; if (res !== v[i].exp) begin errors++; $display("FAIL div_result[%0d]: got %h required %h", i, res, v[i].exp); end
      checks++; if (lat !== v[i].lat) begin errors++; $display("FAIL div_latency[%0d]: got %0d required %0d", i, lat, v[i].lat); end
      checks++; if (rdo !== 5'(20 + i)) begin errors++; $display("FAIL div_rd[%0d]: got %0d required %0d", i, rdo, 20 + i); end
    end
  endtask

  task automatic test_special();
    vec_t v[4];
    logic [31:0] res; logic [4:0] rdo; int lat, stalls; logic sd;
    v[0] = '{op: OP_DIV, a: 32'd5,         b: 32'd0,         exp: 32'hFFFF_FFFF, lat: 1};
    v[1] = '{op: OP_REM, a: 32'd5,         b: 32'd0,         exp: 32'd5,         lat: 1};
    v[2] = '{op: OP_DIV, a: 32'h8000_0000, b: 32'hFFFF_FFFF, exp: 32'h8000_0000, lat: 1};
    v[3] = '{op: OP_REM, a: 32'h8000_0000, b: 32'hFFFF_FFFF, exp: 32'd0,         lat: 1};
    for (int i = 0; i < 4; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, 5'd7, 0, 0, res, rdo, lat, stalls, sd);
      checks++; if (res !== v[i].exp) begin errors++; $display("FAIL special_result[%0d]: got %h required %h", i, res, v[i].exp); end
      checks++; if (lat !== v[i].lat) begin errors++; $display("FAIL special_latency[%0d]: got %0d required %0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res; logic [4:0] rdo; int lat, stalls; logic sd;
    int done_seen;
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd3, 0, 0, res, rdo, lat, stalls, sd);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL flush_setup_result: got %h required 0000000e", res); end
    i_valid_e = 1'b1; i_op_e = OP_DIV; i_op_a_e = 32'd1000; i_op_b_e = 32'd3; i_rd_e = 5'd9;
    repeat (FLUSH_AT + 1) @(posedge i_clk);
    #1;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b required 1", o_busy); end
    i_flush_h = 1'b1; i_valid_e = 1'b0;
    @(posedge i_clk); #1;
    i_flush_h = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL flush_idle: got busy=%b required 0", o_busy); end
    done_seen = 0;
    for (int i = 0; i < STEPS + 8; i++) begin
      @(posedge i_clk); #1;
      if (o_done) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d strobes required 0", done_seen); end
    checks++; if (o_result !== 32'd14) begin errors++; $display("FAIL flush_result_hold: got %h required 0000000e", o_result); end
    checks++; if (o_rd !== 5'd3) begin errors++; $display("FAIL flush_rd_hold: got %0d required 3", o_rd); end
    $display("flush at calc cycle %0d: busy=%b result=%h", FLUSH_AT, o_busy, o_result);
  endtask

  task automatic test_reset_mid();
    i_valid_e = 1'b1; i_op_e = OP_DIV; i_op_a_e = 32'd77; i_op_b_e = 32'd5; i_rd_e = 5'd12;
    repeat (RESET_AT + 1) @(posedge i_clk);
    #1;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b required 1", o_busy); end
    i_rst = 1'b0; i_valid_e = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b required 0", o_done); end
    checks++; if (o_result !== 32'h0) begin errors++; $display("FAIL rstmid_result: got %h required 0", o_result); end
    checks++; if (o_rd !== 5'd0) begin errors++; $display("FAIL rstmid_rd: got %0d required 0", o_rd); end
    $display("reset mid-op: busy=%b result=%h rd=%0d", o_busy, o_result, o_rd);
    @(posedge i_clk); #2;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_clk_en();
    logic [31:0] res; logic [4:0] rdo; int lat, stalls; logic sd;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd14, 3, 5, res, rdo, lat, stalls, sd);
    checks++; if (lat !== DIV_LAT + 5) begin errors++; $display("FAIL clken_latency: got %0d required %0d", lat, DIV_LAT + 5); end
    checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL clken_result: got %h required fffffffd", res); end
    checks++; if (stalls !== DIV_LAT + 5) begin errors++; $display("FAIL clken_stall_cycles: got %0d required %0d", stalls, DIV_LAT + 5); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; logic [4:0] rdo; int lat, stalls; logic sd;
    run_op(OP_MUL, 32'd6, 32'd7, 5'd3, 0, 0, res, rdo, lat, stalls, sd);
    checks++; if (res !== 32'd42) begin errors++; $display("FAIL b2b_first_result: got %h required 0000002a", res); end
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd4, 0, 0, res, rdo, lat, stalls, sd);
    checks++; if (res !== 32'd1) begin errors++; $display("FAIL b2b_second_result: got %h required 00000001", res); end
    checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL b2b_second_latency: got %0d required %0d", lat, MUL_LAT); end
    checks++; if (o_rd !== 5'd4) begin errors++; $display("FAIL b2b_rd_hold: got %0d required 4", o_rd); end
    checks++; if (o_result !== 32'd1) begin errors++; $display("FAIL b2b_result_hold: got %h required 00000001", o_result); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_clk_en();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
